// File: rtl/m_seq_ctrl.sv
// m_seq_ctrl: sequencer for the RV32M unit. Accepts one M-extension op,
// owns the R/D/Z operand registers, steers the datapath mux selects and
// runs a single-pass multiply or a 32-iteration restoring divide.
`timescale 1ns/1ps

`ifndef MUX_MULTA_LENGTH
`define MUX_MULTA_LENGTH      2
`define MUX_MULTA_ZERO        2'd0
`define MUX_MULTA_R_UNSIGNED  2'd1
`define MUX_MULTA_R_SIGNED    2'd2
`endif

`ifndef MUX_MULTB_LENGTH
`define MUX_MULTB_LENGTH      2
`define MUX_MULTB_ZERO        2'd0
`define MUX_MULTB_D_UNSIGNED  2'd1
`define MUX_MULTB_D_SIGNED    2'd2
`endif

`ifndef MUX_DIV_REM_LENGTH
`define MUX_DIV_REM_LENGTH    1
`define MUX_DIV_REM_Z         1'b0
`define MUX_DIV_REM_R         1'b1
`endif

module m_seq_ctrl (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [2:0]                     in_funct3,
  input  logic [31:0]                    in_rs1,
  input  logic [31:0]                    in_rs2,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [31:0]                    out_result,
  output logic [`MUX_MULTA_LENGTH-1:0]   mux_multA,
  output logic [`MUX_MULTB_LENGTH-1:0]   mux_multB,
  output logic [`MUX_DIV_REM_LENGTH-1:0] mux_div_rem,
  output logic [31:0]                    R,
  output logic [62:0]                    D,
  output logic [31:0]                    Z,
  input  logic [62:0]                    sub_result,
  input  logic [63:0]                    product,
  input  logic [31:0]                    div_rem,
  input  logic [31:0]                    div_rem_neg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] r_q, r_d;
  logic [62:0] d_q, d_d;
  logic [31:0] z_q, z_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic        negq_q, negq_d;   // quotient must be negated
  logic        negr_q, negr_d;   // remainder must be negated
  logic [31:0] res_q, res_d;
  logic        ovld_q, ovld_d;

  // Signed DIV/REM take magnitudes; multiplies pass operands through raw.
  logic        signed_div;
  logic [31:0] abs_rs1, abs_rs2;
  logic        sub_ok;
  logic        fix_neg;

  // Only sign bit and low word of the subtract are meaningful to us.
  logic        unused_sub;
  assign unused_sub = ^sub_result[61:32];

  assign R          = r_q;
  assign D          = d_q;
  assign Z          = z_q;
  assign out_result = res_q;
  assign out_valid  = ovld_q;
  assign in_ready   = (state_q == S_IDLE);

  assign signed_div = in_funct3[2] & ~in_funct3[0];
  assign abs_rs1    = (signed_div && in_rs1[31]) ? 32'd0 - in_rs1 : in_rs1;
  assign abs_rs2    = (signed_div && in_rs2[31]) ? 32'd0 - in_rs2 : in_rs2;

  // D[62:32] guard: the 63-bit subtract wraps once D reaches 2^62, so the
  // sign bit alone cannot be trusted while D still has upper bits set.
  assign sub_ok  = (d_q[62:32] == 31'd0) && !sub_result[62];
  assign fix_neg = f3_q[1] ? negr_q : negq_q;

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      d_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      f3_q    <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      res_q   <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      d_q     <= d_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      res_q   <= res_d;
      ovld_q  <= ovld_d;
    end
  end

  // Next-state, register updates and mux selects per state.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    d_d         = d_q;
    z_d         = z_q;
    cnt_d       = cnt_q;
    f3_d        = f3_q;
    negq_d      = negq_q;
    negr_d      = negr_q;
    res_d       = res_q;
    ovld_d      = ovld_q;
    mux_multA   = `MUX_MULTA_ZERO;
    mux_multB   = `MUX_MULTB_ZERO;
    mux_div_rem = `MUX_DIV_REM_Z;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          f3_d   = in_funct3;
          negq_d = signed_div && (in_rs1[31] ^ in_rs2[31]) && (in_rs2 != 32'd0);
          negr_d = signed_div && in_rs1[31];
          r_d    = abs_rs1;
          d_d    = {abs_rs2, 31'd0};
          if (in_funct3[2]) begin
            z_d     = '0;
            cnt_d   = '0;
            state_d = S_DIV;
          end else begin
            state_d = S_MUL;
          end
        end
      end

      S_MUL: begin
        mux_multA = (f3_q[1:0] == 2'b01 || f3_q[1:0] == 2'b10) ?
                    `MUX_MULTA_R_SIGNED : `MUX_MULTA_R_UNSIGNED;
        mux_multB = (f3_q[1:0] == 2'b01) ?
                    `MUX_MULTB_D_SIGNED : `MUX_MULTB_D_UNSIGNED;
        res_d     = (f3_q[1:0] == 2'b00) ? product[31:0] : product[63:32];
        ovld_d    = 1'b1;
        state_d   = S_DONE;
      end

      S_DIV: begin
        if (sub_ok) r_d = sub_result[31:0];
        z_d   = {z_q[30:0], sub_ok};
        d_d   = d_q >> 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end

      S_FIX: begin
        mux_div_rem = f3_q[1] ? `MUX_DIV_REM_R : `MUX_DIV_REM_Z;
        res_d       = fix_neg ? div_rem_neg : div_rem;
        ovld_d      = 1'b1;
        state_d     = S_DONE;
      end

      S_DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: begin
        ovld_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
